// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: shares one 4x4 shift-add multiplier core between two
// requesters. It grants round-robin, launches the core and returns the product
// with a one-cycle ack. A watchdog aborts a hung multiplication.
//
// Handshakes:
//   req/ack     : req[i] is held high until ack[i]. ack[i] is a one-cycle pulse.
//                 prod and resp_err are valid in the ack cycle. The ack is sent
//                 even if req[i] drops mid-operation. A req that is low when
//                 IDLE samples it is never granted.
//   start/ready : mul_start pulses for one cycle. mul_a/mul_b stay stable until
//                 the operation ends. mul_ready is ignored in the cycle after
//                 the pulse, because it may still be high from idle. After that,
//                 the first high mul_ready completes the operation.
module mul_share_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CW      = 8
) (
    input  logic       ck,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [3:0] opa0,
    input  logic [3:0] opb0,
    input  logic [3:0] opa1,
    input  logic [3:0] opb1,
    output logic [1:0] ack,
    output logic [7:0] prod,
    output logic       resp_err,
    output logic       err_sticky,
    output logic       mul_start,
    output logic [3:0] mul_a,
    output logic [3:0] mul_b,
    input  logic [7:0] mul_p,
    input  logic       mul_ready,
    // state encoding: 0 IDLE, 1 LAUNCH, 2 SKIP, 3 BUSY, 4 DONE
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        SKIP   = 3'd2,
        BUSY   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic          winner;   // requester currently being served
    logic          rr;       // requester that wins when both ask
    logic          pick;     // winner candidate while in IDLE
    logic [CW-1:0] wd;       // BUSY cycles spent without ready

    assign dbg_state = state;

    // Choose the requester to grant: rr decides ties, otherwise the sole asker.
    always_comb begin
        pick = (req == 2'b11) ? rr : req[1];
    end

    // Controller: sequences grant, launch, wait and completion. All outputs are registered.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            winner     <= 1'b0;
            rr         <= 1'b0;
            wd         <= '0;
            ack        <= 2'b00;
            prod       <= 8'h00;
            resp_err   <= 1'b0;
            err_sticky <= 1'b0;
            mul_start  <= 1'b0;
            mul_a      <= 4'h0;
            mul_b      <= 4'h0;
        end else begin
            mul_start <= 1'b0;
            ack       <= 2'b00;
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        winner    <= pick;
                        mul_a     <= pick ? opa1 : opa0;
                        mul_b     <= pick ? opb1 : opb0;
                        mul_start <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    state <= SKIP;
                end
                SKIP: begin
                    wd    <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    if (mul_ready) begin
                        prod     <= mul_p;
                        resp_err <= 1'b0;
                        ack      <= winner ? 2'b10 : 2'b01;
                        state    <= DONE;
                    end else if (wd == WD_LAST) begin
                        prod       <= 8'h00;
                        resp_err   <= 1'b1;
                        err_sticky <= 1'b1;
                        ack        <= winner ? 2'b10 : 2'b01;
                        state      <= DONE;
                    end else begin
                        wd <= wd + CW'(1);
                    end
                end
                DONE: begin
                    rr    <= ~winner;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Testbench for mul_share_ctrl. A behavioural multiplier core with a
// programmable latency is attached. Each issued transaction pushes its expected
// response, and a monitor checks each ack against that response.
module tb_mul_share_ctrl;

    localparam int TIMEOUT = 16;

    logic       ck = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [3:0] opa0, opb0, opa1, opb1;
    logic [1:0] ack;
    logic [7:0] prod;
    logic       resp_err, err_sticky, mul_start;
    logic [3:0] mul_a, mul_b;
    logic [7:0] mul_p;
    logic       mul_ready;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [10:0] exp_q[$];     // {ack, resp_err, prod}
    int          d_q[$];       // core latency per launch, in grant order
    logic        rr_m = 1'b0;  // reference: who wins a tie next
    int          grants_exp = 0;
    int          starts_seen = 0;
    logic        exp_sticky = 1'b0;
    logic        prev_start = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 ck = ~ck;

    mul_share_ctrl #(.TIMEOUT(TIMEOUT), .CW(8)) dut (
        .ck(ck), .rst(rst), .req(req),
        .opa0(opa0), .opb0(opb0), .opa1(opa1), .opb1(opb1),
        .ack(ack), .prod(prod), .resp_err(resp_err), .err_sticky(err_sticky),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_p(mul_p), .mul_ready(mul_ready), .dbg_state(dbg_state)
    );

    // ---------------- behavioural core ----------------
    // Latency d: ready rises in the d-th BUSY cycle. With core_skip_hi set,
    // ready also stays high during the SKIP cycle. The product is taken from
    // mul_a/mul_b when the operation completes.
    logic       core_busy = 1'b0;
    int         core_cnt = 0;
    int         core_d = 1;
    logic [7:0] core_p = 8'h00;
    logic       core_skip_hi = 1'b0;

    always @(posedge ck) begin
        if (mul_start) begin
            core_busy <= 1'b1;
            core_cnt  <= 1;
            if (d_q.size() > 0) core_d <= d_q.pop_front();
            else core_d <= 1;
        end else if (core_busy) begin
            core_cnt <= core_cnt + 1;
            if (core_cnt == core_d) begin
                core_busy <= 1'b0;
                core_p    <= {4'b0, mul_a} * {4'b0, mul_b};
            end
        end
    end

    assign mul_ready = !core_busy || (core_skip_hi && core_cnt == 1);
    assign mul_p     = core_p;

    // ---------------- checking helper ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge ck) begin
        logic [10:0] e;
        if (rst) begin
            exp_sticky = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (mul_start) begin
                starts_seen++;
                chk("start_single_cycle", {31'b0, prev_start}, 32'd0);
            end
            prev_start = mul_start;
            if (ack != 2'b00) begin
                chk("ack_onehot", {31'b0, ack == 2'b11}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", {30'b0, ack}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_resp", {21'b0, ack, resp_err, prod}, {21'b0, e});
                    exp_sticky = exp_sticky | e[8];
                    chk("err_sticky", {31'b0, err_sticky}, {31'b0, exp_sticky});
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_txn(input logic [1:0] r, input logic [3:0] a0, input logic [3:0] b0,
                          input logic [3:0] a1, input logic [3:0] b1,
                          input int d0, input int d1, input bit skh, input bit scr);
        logic order[$];
        logic w;
        int   left, d, pv;
        bit   scrambled;
        opa0 = a0; opb0 = b0; opa1 = a1; opb1 = b1;
        core_skip_hi = skh;
        if (r == 2'b11) begin
            order.push_back(rr_m);
            order.push_back(~rr_m);
        end else begin
            order.push_back(r[1]);
        end
        foreach (order[k]) begin
            w  = order[k];
            d  = w ? d1 : d0;
            pv = w ? int'(a1) * int'(b1) : int'(a0) * int'(b0);
            d_q.push_back(d);
            if (d > TIMEOUT) exp_q.push_back({w ? 2'b10 : 2'b01, 1'b1, 8'h00});
            else exp_q.push_back({w ? 2'b10 : 2'b01, 1'b0, 8'(pv)});
            rr_m = ~w;
            grants_exp++;
        end
        req = r;
        left = order.size();
        scrambled = 1'b0;
        for (int cyc = 0; cyc < 200 && left > 0; cyc++) begin
            @(negedge ck);
            if (scr && !scrambled && mul_start) begin
                scrambled = 1'b1;
                if (order[0]) begin
                    opa1 = 4'($urandom); opb1 = 4'($urandom);
                end else begin
                    opa0 = 4'($urandom); opb0 = 4'($urandom);
                end
            end
            if (ack != 2'b00) begin
                req = req & ~ack;
                left--;
            end
        end
        chk("ack_wait", left, 0);
        req = 2'b00;
        @(negedge ck);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int dd;
        rst = 1'b1; req = 2'b00;
        opa0 = 4'h0; opb0 = 4'h0; opa1 = 4'h0; opb1 = 4'h0;
        #2;
        chk("rst_ack", {30'b0, ack}, 32'd0);
        chk("rst_prod", {24'b0, prod}, 32'd0);
        chk("rst_start", {31'b0, mul_start}, 32'd0);
        chk("rst_sticky", {31'b0, err_sticky}, 32'd0);
        repeat (2) @(negedge ck);
        rst = 1'b0;
        @(negedge ck);

        // single request, 0xF * 0xD
        do_txn(2'b01, 4'hF, 4'hD, 4'h0, 4'h0, 8, 1, 1'b0, 1'b0);
        // contention, both held, twice
        do_txn(2'b11, 4'h3, 4'h5, 4'h7, 4'h9, 2, 3, 1'b0, 1'b0);
        do_txn(2'b11, 4'h3, 4'h5, 4'h7, 4'h9, 1, 4, 1'b0, 1'b0);
        // ready still high in SKIP must be ignored
        do_txn(2'b01, 4'h6, 4'hB, 4'h0, 4'h0, 5, 1, 1'b1, 1'b0);
        // hung core, then boundary latencies around the watchdog
        do_txn(2'b10, 4'h0, 4'h0, 4'hA, 4'h5, 1, 255, 1'b0, 1'b0);
        do_txn(2'b10, 4'h0, 4'h0, 4'h4, 4'h4, 1, TIMEOUT, 1'b0, 1'b0);
        do_txn(2'b01, 4'h5, 4'h5, 4'h0, 4'h0, TIMEOUT + 1, 1, 1'b0, 1'b0);
        do_txn(2'b01, 4'h2, 4'h3, 4'h0, 4'h0, 1, 1, 1'b0, 1'b0);
        // operands change after launch
        do_txn(2'b01, 4'h2, 4'h7, 4'h0, 4'h0, 3, 1, 1'b0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            dd = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(1, TIMEOUT + 2);
            do_txn(2'($urandom_range(1, 3)), 4'($urandom), 4'($urandom), 4'($urandom),
                   4'($urandom), dd, $urandom_range(1, TIMEOUT + 2),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // good op leaves a nonzero prod, then reset during a hung operation
        do_txn(2'b01, 4'hF, 4'hF, 4'h0, 4'h0, 2, 1, 1'b0, 1'b0);
        opa1 = 4'h6; opb1 = 4'h7; core_skip_hi = 1'b0;
        d_q.push_back(255);
        grants_exp++;
        req = 2'b10;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge ck);
            if (mul_start) break;
        end
        repeat (4) @(negedge ck);
        #2 rst = 1'b1;
        #1;
        chk("midrst_ack", {30'b0, ack}, 32'd0);
        chk("midrst_prod", {24'b0, prod}, 32'd0);
        chk("midrst_err", {31'b0, resp_err}, 32'd0);
        chk("midrst_sticky", {31'b0, err_sticky}, 32'd0);
        chk("midrst_start", {31'b0, mul_start}, 32'd0);
        chk("midrst_ab", {24'b0, mul_a, mul_b}, 32'd0);
        chk("midrst_state", {29'b0, dbg_state}, 32'd0);
        @(negedge ck);
        @(negedge ck);
        #1 rst = 1'b0;
        rr_m = 1'b0;
        d_q.push_back(3);
        exp_q.push_back({2'b10, 1'b0, 8'h2A});
        grants_exp++;
        begin
            int left;
            left = 1;
            for (int cyc = 0; cyc < 60 && left > 0; cyc++) begin
                @(negedge ck);
                if (ack != 2'b00) left--;
            end
            chk("post_rst_ack_wait", left, 0);
        end
        req = 2'b00;
        repeat (5) @(negedge ck);

        chk("queue_drained", exp_q.size(), 0);
        chk("start_count", starts_seen, grants_exp);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
